// File: rtl/maxpool12_k3_2d.sv
// Streaming 3x3 max-pool over 12 parallel channels of signed pixels in raster order.
// Two line buffers per channel feed a sliding window; strided windows emit a registered result.
module maxpool12_k3_2d #(
  parameter int unsigned IMG_Width  = 3,
  parameter int unsigned IMG_Height = 3,
  parameter int unsigned Datawidth  = 32,
  parameter int unsigned Stride     = 2,
  parameter int unsigned ReLU       = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [Datawidth-1:0] In_0,
  input  logic [Datawidth-1:0] In_1,
  input  logic [Datawidth-1:0] In_2,
  input  logic [Datawidth-1:0] In_3,
  input  logic [Datawidth-1:0] In_4,
  input  logic [Datawidth-1:0] In_5,
  input  logic [Datawidth-1:0] In_6,
  input  logic [Datawidth-1:0] In_7,
  input  logic [Datawidth-1:0] In_8,
  input  logic [Datawidth-1:0] In_9,
  input  logic [Datawidth-1:0] In_10,
  input  logic [Datawidth-1:0] In_11,
  input  logic                 valid_in,
  output logic                 valid_out,
  output logic [Datawidth-1:0] Out_0,
  output logic [Datawidth-1:0] Out_1,
  output logic [Datawidth-1:0] Out_2,
  output logic [Datawidth-1:0] Out_3,
  output logic [Datawidth-1:0] Out_4,
  output logic [Datawidth-1:0] Out_5,
  output logic [Datawidth-1:0] Out_6,
  output logic [Datawidth-1:0] Out_7,
  output logic [Datawidth-1:0] Out_8,
  output logic [Datawidth-1:0] Out_9,
  output logic [Datawidth-1:0] Out_10,
  output logic [Datawidth-1:0] Out_11
);

  localparam int unsigned NumCh   = 12;
  localparam int unsigned ColW    = $clog2(IMG_Width);
  localparam int unsigned RowW    = $clog2(IMG_Height);
  localparam bit          UseRelu = (ReLU != 0);

  typedef logic signed [Datawidth-1:0] pix_t;

  pix_t in_px [NumCh];

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  // lb0 holds row r-1, lb1 holds row r-2, indexed by column.
  pix_t lb0_q [NumCh][IMG_Width];
  pix_t lb1_q [NumCh][IMG_Width];

  // Window columns c-2 (index 0) and c-1 (index 1); column c comes straight from
  // the line buffers and the input so the max covers all nine values on the accept edge.
  pix_t win_q [NumCh][3][2];

  pix_t max_val [NumCh];
  pix_t res     [NumCh];
  pix_t out_q   [NumCh];
  logic valid_q;
  logic fire;

  int unsigned row_off, col_off;

  assign in_px[0]  = In_0;
  assign in_px[1]  = In_1;
  assign in_px[2]  = In_2;
  assign in_px[3]  = In_3;
  assign in_px[4]  = In_4;
  assign in_px[5]  = In_5;
  assign in_px[6]  = In_6;
  assign in_px[7]  = In_7;
  assign in_px[8]  = In_8;
  assign in_px[9]  = In_9;
  assign in_px[10] = In_10;
  assign in_px[11] = In_11;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (32'(col_q) == IMG_Width - 1) begin
        col_d = '0;
        row_d = (32'(row_q) == IMG_Height - 1) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    row_off = 32'(row_q) - 32'd2;
    col_off = 32'(col_q) - 32'd2;
    fire = valid_in && (32'(row_q) >= 32'd2) && (32'(col_q) >= 32'd2) &&
           ((row_off % Stride) == 0) && ((col_off % Stride) == 0);
  end

  always_comb begin
    for (int ch = 0; ch < NumCh; ch++) begin
      max_val[ch] = win_q[ch][0][0];
      for (int rr = 0; rr < 3; rr++) begin
        for (int cc = 0; cc < 2; cc++) begin
          if (win_q[ch][rr][cc] > max_val[ch]) max_val[ch] = win_q[ch][rr][cc];
        end
      end
      if (lb1_q[ch][col_q] > max_val[ch]) max_val[ch] = lb1_q[ch][col_q];
      if (lb0_q[ch][col_q] > max_val[ch]) max_val[ch] = lb0_q[ch][col_q];
      if (in_px[ch] > max_val[ch])        max_val[ch] = in_px[ch];
      res[ch] = (UseRelu && max_val[ch][Datawidth-1]) ? '0 : max_val[ch];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= fire;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < NumCh; ch++) begin
        for (int x = 0; x < IMG_Width; x++) begin
          lb0_q[ch][x] <= '0;
          lb1_q[ch][x] <= '0;
        end
        for (int rr = 0; rr < 3; rr++) begin
          win_q[ch][rr][0] <= '0;
          win_q[ch][rr][1] <= '0;
        end
      end
    end else if (valid_in) begin
      for (int ch = 0; ch < NumCh; ch++) begin
        lb1_q[ch][col_q] <= lb0_q[ch][col_q];
        lb0_q[ch][col_q] <= in_px[ch];
        for (int rr = 0; rr < 3; rr++) begin
          win_q[ch][rr][0] <= win_q[ch][rr][1];
        end
        win_q[ch][0][1] <= lb1_q[ch][col_q];
        win_q[ch][1][1] <= lb0_q[ch][col_q];
        win_q[ch][2][1] <= in_px[ch];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < NumCh; ch++) out_q[ch] <= '0;
    end else if (fire) begin
      for (int ch = 0; ch < NumCh; ch++) out_q[ch] <= res[ch];
    end
  end

  assign valid_out = valid_q;
  assign Out_0     = out_q[0];
  assign Out_1     = out_q[1];
  assign Out_2     = out_q[2];
  assign Out_3     = out_q[3];
  assign Out_4     = out_q[4];
  assign Out_5     = out_q[5];
  assign Out_6     = out_q[6];
  assign Out_7     = out_q[7];
  assign Out_8     = out_q[8];
  assign Out_9     = out_q[9];
  assign Out_10    = out_q[10];
  assign Out_11    = out_q[11];

endmodule

// File: tb/tb_maxpool12_k3_2d.sv
// Bench for maxpool12_k3_2d: three instances (3x3, 5x5, 3x3 with ReLU) checked pixel by
// pixel against a frame-level window-max model.
module tb_maxpool12_k3_2d;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v_a = 1'b0, v_b = 1'b0, v_c = 1'b0;
  logic [31:0] in_px [12];
  logic        vo_a, vo_b, vo_c;
  logic [31:0] out_a [12];
  logic [31:0] out_b [12];
  logic [31:0] out_c [12];

  int n_checks = 0;
  int n_fail   = 0;
  int stim [0:255][12];
  logic [31:0] last_a [12];
  logic [31:0] last_b [12];
  logic [31:0] last_c [12];
  logic        smp_v;
  logic [31:0] smp_o [12];

  always #5 clk = ~clk;

  maxpool12_k3_2d #(.IMG_Width(3), .IMG_Height(3), .Datawidth(32), .Stride(2), .ReLU(0)) u_a (
    .clk(clk), .rst(rst), .valid_in(v_a), .valid_out(vo_a),
    .In_0(in_px[0]), .In_1(in_px[1]), .In_2(in_px[2]), .In_3(in_px[3]), .In_4(in_px[4]),
    .In_5(in_px[5]), .In_6(in_px[6]), .In_7(in_px[7]), .In_8(in_px[8]), .In_9(in_px[9]),
    .In_10(in_px[10]), .In_11(in_px[11]),
    .Out_0(out_a[0]), .Out_1(out_a[1]), .Out_2(out_a[2]), .Out_3(out_a[3]), .Out_4(out_a[4]),
    .Out_5(out_a[5]), .Out_6(out_a[6]), .Out_7(out_a[7]), .Out_8(out_a[8]), .Out_9(out_a[9]),
    .Out_10(out_a[10]), .Out_11(out_a[11])
  );

  maxpool12_k3_2d #(.IMG_Width(5), .IMG_Height(5), .Datawidth(32), .Stride(2), .ReLU(0)) u_b (
    .clk(clk), .rst(rst), .valid_in(v_b), .valid_out(vo_b),
    .In_0(in_px[0]), .In_1(in_px[1]), .In_2(in_px[2]), .In_3(in_px[3]), .In_4(in_px[4]),
    .In_5(in_px[5]), .In_6(in_px[6]), .In_7(in_px[7]), .In_8(in_px[8]), .In_9(in_px[9]),
    .In_10(in_px[10]), .In_11(in_px[11]),
    .Out_0(out_b[0]), .Out_1(out_b[1]), .Out_2(out_b[2]), .Out_3(out_b[3]), .Out_4(out_b[4]),
    .Out_5(out_b[5]), .Out_6(out_b[6]), .Out_7(out_b[7]), .Out_8(out_b[8]), .Out_9(out_b[9]),
    .Out_10(out_b[10]), .Out_11(out_b[11])
  );

  maxpool12_k3_2d #(.IMG_Width(3), .IMG_Height(3), .Datawidth(32), .Stride(2), .ReLU(1)) u_c (
    .clk(clk), .rst(rst), .valid_in(v_c), .valid_out(vo_c),
    .In_0(in_px[0]), .In_1(in_px[1]), .In_2(in_px[2]), .In_3(in_px[3]), .In_4(in_px[4]),
    .In_5(in_px[5]), .In_6(in_px[6]), .In_7(in_px[7]), .In_8(in_px[8]), .In_9(in_px[9]),
    .In_10(in_px[10]), .In_11(in_px[11]),
    .Out_0(out_c[0]), .Out_1(out_c[1]), .Out_2(out_c[2]), .Out_3(out_c[3]), .Out_4(out_c[4]),
    .Out_5(out_c[5]), .Out_6(out_c[6]), .Out_7(out_c[7]), .Out_8(out_c[8]), .Out_9(out_c[9]),
    .Out_10(out_c[10]), .Out_11(out_c[11])
  );

  // Reference: does stream pixel p close a strided window in a w x h frame?
  function automatic bit is_fire(int w, int h, int s, int p);
    int q, r, c;
    q = p % (w * h);
    r = q / w;
    c = q % w;
    return (r >= 2) && (c >= 2) && ((r - 2) % s == 0) && ((c - 2) % s == 0);
  endfunction

  // Reference: max of the 3x3 block of the current frame ending at pixel p.
  function automatic logic [31:0] pool_ref(int w, int h, int p, int ch, bit relu);
    int q, base, r, c, m;
    q    = p % (w * h);
    base = p - q;
    r    = q / w;
    c    = q % w;
    m    = stim[base + (r - 2) * w + (c - 2)][ch];
    for (int rr = r - 2; rr <= r; rr++)
      for (int cc = c - 2; cc <= c; cc++)
        if (stim[base + rr * w + cc][ch] > m) m = stim[base + rr * w + cc][ch];
    if (relu && m < 0) m = 0;
    return 32'(m);
  endfunction

  task automatic drive(input int sel, input int p);
    @(negedge clk);
    for (int k = 0; k < 12; k++) in_px[k] = 32'(stim[p][k]);
    v_a = (sel == 0);
    v_b = (sel == 1);
    v_c = (sel == 2);
    @(posedge clk);
    #1;
    v_a = 1'b0;
    v_b = 1'b0;
    v_c = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic sample_out(input int sel);
    for (int k = 0; k < 12; k++) begin
      smp_o[k] = (sel == 0) ? out_a[k] : (sel == 1) ? out_b[k] : out_c[k];
    end
    smp_v = (sel == 0) ? vo_a : (sel == 1) ? vo_b : vo_c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v_a = 1'b1;
    for (int k = 0; k < 12; k++) in_px[k] = 32'($urandom);
    repeat (2) idle_cycle();
    for (int sel = 0; sel < 3; sel++) begin
      sample_out(sel);
      n_checks++;
      if (smp_v !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_valid dut=%0d got=%b exp=0", sel, smp_v);
      end
      for (int k = 0; k < 12; k++) begin
        n_checks++;
        if (smp_o[k] !== 32'd0) begin
          n_fail++;
          $display("FAIL reset_out dut=%0d ch=%0d got=%0d exp=0", sel, k, smp_o[k]);
        end
      end
    end
    @(negedge clk);
    v_a = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      last_a[k] = '0;
      last_b[k] = '0;
      last_c[k] = '0;
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic [31:0] e;
    for (int p = 0; p < 108; p++) for (int k = 0; k < 12; k++) stim[p][k] = p + 1;
    for (int p = 0; p < 108; p++) begin
      drive(0, p);
      sample_out(0);
      n_checks++;
      if (smp_v !== 1'(is_fire(3, 3, 2, p))) begin
        n_fail++;
        $display("FAIL b2b_valid p=%0d got=%b exp=%b", p, smp_v, is_fire(3, 3, 2, p));
      end
      if (is_fire(3, 3, 2, p)) begin
        pulses++;
        for (int k = 0; k < 12; k++) last_a[k] = pool_ref(3, 3, p, k, 1'b0);
      end
      for (int k = 0; k < 12; k++) begin
        e = last_a[k];
        n_checks++;
        if (smp_o[k] !== e) begin
          n_fail++;
          $display("FAIL b2b_out p=%0d ch=%0d got=%0d exp=%0d", p, k,
                   $signed(smp_o[k]), $signed(e));
        end
      end
    end
    n_checks++;
    if (pulses != 12) begin
      n_fail++;
      $display("FAIL b2b_pulse_count got=%0d exp=12", pulses);
    end
  endtask

  task automatic test_gaps();
    int gap;
    for (int p = 0; p < 108; p++) for (int k = 0; k < 12; k++) stim[p][k] = p + 1;
    for (int p = 0; p < 108; p++) begin
      gap = (p == 0) ? 0 : int'($urandom_range(3, 1));
      for (int g = 0; g < gap; g++) begin
        idle_cycle();
        n_checks++;
        if (vo_a !== 1'b0 || out_a[0] !== last_a[0]) begin
          n_fail++;
          $display("FAIL gap_idle p=%0d got_v=%b got=%0d exp_v=0 exp=%0d", p, vo_a,
                   $signed(out_a[0]), $signed(last_a[0]));
        end
      end
      drive(0, p);
      sample_out(0);
      n_checks++;
      if (smp_v !== 1'(is_fire(3, 3, 2, p))) begin
        n_fail++;
        $display("FAIL gap_valid p=%0d got=%b exp=%b", p, smp_v, is_fire(3, 3, 2, p));
      end
      if (is_fire(3, 3, 2, p)) begin
        for (int k = 0; k < 12; k++) begin
          last_a[k] = pool_ref(3, 3, p, k, 1'b0);
          n_checks++;
          if (smp_o[k] !== last_a[k]) begin
            n_fail++;
            $display("FAIL gap_out p=%0d ch=%0d got=%0d exp=%0d", p, k,
                     $signed(smp_o[k]), $signed(last_a[k]));
          end
        end
      end
    end
  endtask

  task automatic test_5x5();
    int pulses = 0;
    for (int p = 0; p < 25; p++) for (int k = 0; k < 12; k++) stim[p][k] = p + 1;
    for (int p = 25; p < 75; p++) for (int k = 0; k < 12; k++) stim[p][k] = int'($urandom);
    for (int p = 0; p < 75; p++) begin
      if ($urandom_range(3, 0) == 0) idle_cycle();
      drive(1, p);
      sample_out(1);
      n_checks++;
      if (smp_v !== 1'(is_fire(5, 5, 2, p))) begin
        n_fail++;
        $display("FAIL w5_valid p=%0d got=%b exp=%b", p, smp_v, is_fire(5, 5, 2, p));
      end
      if (is_fire(5, 5, 2, p)) begin
        pulses++;
        for (int k = 0; k < 12; k++) last_b[k] = pool_ref(5, 5, p, k, 1'b0);
      end
      for (int k = 0; k < 12; k++) begin
        n_checks++;
        if (smp_o[k] !== last_b[k]) begin
          n_fail++;
          $display("FAIL w5_out p=%0d ch=%0d got=%0d exp=%0d", p, k,
                   $signed(smp_o[k]), $signed(last_b[k]));
        end
      end
    end
    n_checks++;
    if (pulses != 12) begin
      n_fail++;
      $display("FAIL w5_pulse_count got=%0d exp=12", pulses);
    end
  endtask

  task automatic test_channels();
    for (int p = 0; p < 9; p++) begin
      for (int k = 0; k < 11; k++) stim[p][k] = (p + 1) * (k + 1);
      stim[p][11] = -(p + 1);
    end
    for (int p = 0; p < 9; p++) drive(0, p);
    sample_out(0);
    n_checks++;
    if (smp_v !== 1'b1) begin
      n_fail++;
      $display("FAIL chan_valid got=%b exp=1", smp_v);
    end
    for (int k = 0; k < 12; k++) begin
      last_a[k] = pool_ref(3, 3, 8, k, 1'b0);
      n_checks++;
      if (smp_o[k] !== last_a[k]) begin
        n_fail++;
        $display("FAIL chan_out ch=%0d got=%0d exp=%0d", k, $signed(smp_o[k]),
                 $signed(last_a[k]));
      end
    end
  endtask

  task automatic test_relu();
    logic [31:0] e;
    for (int p = 0; p < 9; p++) for (int k = 0; k < 12; k++) stim[p][k] = -5;
    for (int p = 0; p < 9; p++) drive(0, p);
    n_checks++;
    if (vo_a !== 1'b1 || out_a[3] !== 32'hFFFF_FFFB) begin
      n_fail++;
      $display("FAIL relu_off got_v=%b got=%0d exp_v=1 exp=-5", vo_a, $signed(out_a[3]));
    end
    for (int k = 0; k < 12; k++) last_a[k] = 32'hFFFF_FFFB;
    for (int p = 0; p < 9; p++) drive(2, p);
    n_checks++;
    if (vo_c !== 1'b1 || out_c[3] !== 32'd0) begin
      n_fail++;
      $display("FAIL relu_on got_v=%b got=%0d exp_v=1 exp=0", vo_c, $signed(out_c[3]));
    end
    // Random signed frames: roughly a quarter of channels end up with a negative max.
    for (int p = 9; p < 27; p++)
      for (int k = 0; k < 12; k++) stim[p][k] = int'($urandom) | ((k % 4 == 0) ? 32'h8000_0000 : 0);
    for (int p = 9; p < 27; p++) begin
      drive(2, p);
      sample_out(2);
      n_checks++;
      if (smp_v !== 1'(is_fire(3, 3, 2, p))) begin
        n_fail++;
        $display("FAIL relu_valid p=%0d got=%b exp=%b", p, smp_v, is_fire(3, 3, 2, p));
      end
      if (is_fire(3, 3, 2, p)) begin
        for (int k = 0; k < 12; k++) begin
          e = pool_ref(3, 3, p, k, 1'b1);
          n_checks++;
          if (smp_o[k] !== e) begin
            n_fail++;
            $display("FAIL relu_out p=%0d ch=%0d got=%0d exp=%0d", p, k,
                     $signed(smp_o[k]), $signed(e));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int pulses = 0;
    for (int p = 0; p < 9; p++) for (int k = 0; k < 12; k++) stim[p][k] = p + 1;
    for (int p = 0; p < 5; p++) drive(0, p);
    @(negedge clk);
    rst = 1'b1;
    v_a = 1'b1;
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (vo_a !== 1'b0 || out_a[0] !== 32'd0 || out_a[11] !== 32'd0) begin
        n_fail++;
        $display("FAIL midrst_hold got_v=%b got=%0d exp_v=0 exp=0", vo_a, out_a[0]);
      end
    end
    @(negedge clk);
    v_a = 1'b0;
    rst = 1'b0;
    for (int p = 0; p < 9; p++) begin
      drive(0, p);
      if (vo_a === 1'b1) pulses++;
      n_checks++;
      if (vo_a !== 1'(p == 8)) begin
        n_fail++;
        $display("FAIL midrst_valid p=%0d got=%b exp=%b", p, vo_a, p == 8);
      end
    end
    n_checks++;
    if (pulses != 1 || out_a[5] !== 32'd9) begin
      n_fail++;
      $display("FAIL midrst_out pulses=%0d got=%0d exp_pulses=1 exp=9", pulses, out_a[5]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 12; k++) in_px[k] = '0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_5x5();
    test_channels();
    test_relu();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool12_k3_2d.md
Name: maxpool12_k3_2d

Overview:
- Streaming 2D max-pool with a 3x3 kernel, applied to 12 independent channels in parallel.
- Pixels arrive in raster order (row-major), one pixel per channel per accepted cycle.
- For each window position, emits the maximum of the 3x3 window per channel, with optional ReLU.
- Sits between convolution layers in the CNN datapath.

Parameters:
- IMG_Width, 3, input frame width in pixels (>=3).
- IMG_Height, 3, input frame height in pixels (>=3).
- Datawidth, 32, bit width of each pixel (signed two's complement).
- Stride, 2, window step in both x and y (>=1).
- ReLU, 0, 1 = clamp negative results to 0; 0 = pass the max unchanged.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- In_0..In_11  in  Datawidth each  channel 0..11 input pixel; all channels share the same pixel position.
- valid_in  in  1  input pixels valid this cycle; pixel accepted on rising clk edge.
- valid_out  out  1  Out_* hold a new pooled result; one-cycle pulse.
- Out_0..Out_11  out  Datawidth each  channel 0..11 pooled result.

Behaviour:
- Reset (async, rst=1): valid_out=0, all Out_k=0, column/row counters=0, line buffers and window registers cleared. Pixel position returns to (row 0, col 0).
- Acceptance: a pixel is consumed only on an edge with valid_in=1. When valid_in=0, no state advances. Gaps of any length are allowed; results do not depend on gap pattern.
- Position tracking:
  - Column counter 0..IMG_Width-1; row counter 0..IMG_Height-1.
  - After pixel (H-1, W-1), both counters wrap to 0, so back-to-back frames stream with no idle cycle.
- Storage:
  - Per channel: two line buffers of IMG_Width entries holding the previous two rows.
  - Per channel: a 3x3 window register fed from the current input and both line buffers.
- Valid windows (no padding):
  - Bottom-right pixel at (r, c) with r>=2, c>=2, (r-2) mod Stride = 0, (c-2) mod Stride = 0.
  - Outputs per frame = ((IMG_Height-3)/Stride+1) * ((IMG_Width-3)/Stride+1), integer division.
- Arithmetic:
  - Signed comparison over all 9 window values, per channel independently.
  - If ReLU=1 and the max is < 0, output 0. No width growth; output width = Datawidth.
- Latency and hold:
  - Out_k and valid_out are registered.
  - valid_out=1 for exactly one cycle, in the cycle following the edge that accepted the window's bottom-right pixel.
  - Out_k hold their last value until the next result.
- Frame boundary: rows from a previous frame never contribute to the first two rows of a new frame. Windows only fire for r>=2 of the current frame.
- Reset mid-frame: partial frame discarded; the next accepted pixel is (0,0).
- valid_in asserted during reset is ignored.

Test Plan:
- Default params (3x3, S=2, ReLU=0), 12 back-to-back frames, all channels = i for i=1..108 on consecutive valid cycles.
  -> exactly 12 valid_out pulses, one cycle after pixels 9, 18, …, 108 are accepted.
  -> Out_k = 9, 18, …, 108 respectively.
- IMG_Width=IMG_Height=5, S=2, pixels 1..25.
  -> 4 pulses with Out = 13, 15, 23, 25 (bottom-right at (2,2), (2,4), (4,2), (4,4)).
- Channel independence: In_k = value×(k+1), 3x3 frame of 1..9.
  -> Out_k = 9×(k+1); In_11 = -value gives Out_11 = -1.
- Signed/ReLU: frame of all -5 with ReLU=0 -> Out = -5. Same frame with ReLU=1 -> Out = 0.
- Insert valid_in=0 gaps of 1–3 cycles between pixels of the first test.
  -> same 12 values, each pulse one cycle after the corresponding last accepted pixel.
- Assert rst after 5 pixels of a frame, then send a full 1..9 frame.
  -> single pulse with Out = 9; outputs read 0 while in reset.
